// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared constants and FSM state type for the
// register-file dump engine (frame header, size, state enum).
package reg_dump_pkg;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int FRAME_BYTES = 2 + 5 * NREGS;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        DATA,
        CSUM
    } state_t;

endpackage

// File: rtl/reg_dump_if.sv
// reg_dump_if: byte stream with valid/ready handshake.
// master drives out_valid/out_data/out_last, slave drives out_ready.
interface reg_dump_if;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/reg_dump_ser.sv
// reg_dump_ser: 32-bit snapshot register, shifted MSB-first a byte at a time.
// Ports: clk, rst, i_clr, i_load, i_shift, i_data -> o_next, o_wrap.
module reg_dump_ser
    import reg_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic        i_shift,
    input  logic [31:0] i_data,
    output logic [7:0]  o_next,
    output logic        o_wrap
);

    logic [31:0] r_sr;
    logic [1:0]  r_bcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr   <= '0;
            r_bcnt <= '0;
        end else if (i_clr) begin
            r_sr   <= '0;
            r_bcnt <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr   <= {r_sr[23:0], 8'h00};
            r_bcnt <= r_bcnt + 2'd1;
        end
    end

    // Top byte is the one on the wire; the byte below it goes out next.
    assign o_next = r_sr[23:16];
    assign o_wrap = (r_bcnt == 2'd3);

endmodule

// File: rtl/reg_dump.sv
// reg_dump: walks the register file and streams a 162-byte frame
// (A5, {addr,4 data bytes} x 32, XOR checksum). Ports: clk, rst, start,
// rd_addr/rd_data (read port), out (stream master), busy, done.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NREGS_P  = NREGS,
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W_P-1:0] rd_addr,
    input  logic [DATA_W_P-1:0] rd_data,
    reg_dump_if.master          out,
    output logic                busy,
    output logic                done
);

    state_t              r_state;
    logic [ADDR_W_P-1:0] r_idx;
    logic [7:0]          r_chk;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;
    logic                r_done;

    logic       w_hs;
    logic       w_clr;
    logic       w_load;
    logic       w_shift;
    logic [7:0] w_next;
    logic       w_wrap;
    logic       w_lastreg;

    assign w_hs      = r_valid & out.out_ready;
    assign w_clr     = (r_state == IDLE) & start;
    assign w_load    = w_hs & (r_state == ADDR);
    assign w_shift   = w_hs & (r_state == DATA);
    assign w_lastreg = (r_idx == ADDR_W_P'(NREGS_P - 1));

    reg_dump_ser u_ser (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (rd_data[31:0]),
        .o_next  (w_next),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_chk   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= HDR;
                        r_idx   <= '0;
                        r_chk   <= '0;
                        r_data  <= HDR_BYTE;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                HDR: begin
                    if (w_hs) begin
                        r_state <= ADDR;
                        r_data  <= 8'(r_idx);
                    end
                end
                ADDR: begin
                    // Snapshot is taken here; MSB goes straight to the wire.
                    if (w_hs) begin
                        r_state <= DATA;
                        r_chk   <= r_chk ^ r_data;
                        r_data  <= rd_data[31:24];
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        r_chk <= r_chk ^ r_data;
                        if (w_wrap) begin
                            r_idx <= r_idx + 1'b1;
                            if (w_lastreg) begin
                                r_state <= CSUM;
                                r_data  <= r_chk ^ r_data;
                                r_last  <= 1'b1;
                            end else begin
                                r_state <= ADDR;
                                r_data  <= 8'(r_idx + 1'b1);
                            end
                        end else begin
                            r_data <= w_next;
                        end
                    end
                end
                CSUM: begin
                    if (w_hs) begin
                        r_state <= IDLE;
                        r_data  <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_addr       = r_idx;
    assign out.out_valid = r_valid;
    assign out.out_data  = r_data;
    assign out.out_last  = r_last;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed frames against a register-file model with a
// byte scoreboard; covers back-pressure, live writes, start-while-busy, reset.
module tb_reg_dump;
    import reg_dump_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    logic [8:0]  q [$];

    int n_checks = 0;
    int n_errors = 0;
    int n_hs;
    int n_done;
    bit prev_stall;
    logic [7:0] prev_data;
    logic [7:0] last_csum;

    reg_dump_if bus ();

    reg_dump dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .out     (bus.master),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always_comb rd_data = (rd_addr == 5'd0) ? 32'h0 : rf[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] r [32]);
        logic [7:0]  c;
        logic [31:0] v;
        c = 8'h00;
        q.push_back({1'b0, HDR_BYTE});
        for (int i = 0; i < 32; i++) begin
            v = (i == 0) ? 32'h0 : r[i];
            q.push_back({1'b0, 8'(i)});
            c ^= 8'(i);
            for (int b = 3; b >= 0; b--) begin
                q.push_back({1'b0, v[b*8 +: 8]});
                c ^= v[b*8 +: 8];
            end
        end
        q.push_back({1'b1, c});
    endtask

    task automatic step(input bit rnd);
        logic [8:0] e;
        @(negedge clk);
        bus.out_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
        #1;
        if (prev_stall) begin
            check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_data", {24'b0, bus.out_data}, {24'b0, prev_data});
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (done) n_done++;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                check("extra_byte", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check($sformatf("byte%0d", n_hs),
                      {23'b0, bus.out_last, bus.out_data}, {23'b0, e});
            end
            if (bus.out_last) last_csum = bus.out_data;
            n_hs++;
        end
    endtask

    // mode: 0 plain, 1 live writes, 2 start while busy, 3 reset mid-frame
    task automatic run_frame(input bit rnd, input int mode);
        logic [31:0] e [32];
        bit got_done;
        int poked;
        int c;
        prev_stall = 1'b0;
        n_hs = 0;
        n_done = 0;
        poked = 0;
        got_done = 1'b0;
        last_csum = 8'hxx;
        for (int i = 0; i < 32; i++) e[i] = rf[i];
        if (mode == 1) e[31] = 32'h12345678;
        push_frame(e);
        @(negedge clk);
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("first_valid", {31'b0, bus.out_valid}, 32'd1);
        check("first_busy", {31'b0, busy}, 32'd1);
        check("first_hdr", {24'b0, bus.out_data}, 32'hA5);
        for (c = 0; c < 3000; c++) begin
            step(rnd);
            if (start) start = 1'b0;
            if (n_done != 0) begin
                got_done = 1'b1;
                break;
            end
            if (!rnd && mode == 0 && c == 161)
                check("busy_end", {31'b0, busy}, 32'd1);
            if (mode == 1) begin
                if (poked == 0 && rd_addr == 5'd10) begin
                    rf[31] = 32'h12345678;
                    poked = 1;
                end else if (poked == 1) begin
                    rf[3] = 32'hFFFFFFFF;
                    poked = 2;
                end
            end
            if (mode == 2 && poked == 0 && rd_addr == 5'd7) begin
                start = 1'b1;
                poked = 1;
            end
            if (mode == 3 && n_hs == 64) begin
                @(posedge clk);
                #1;
                rst = 1'b1;
                #1;
                check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
                check("rst_busy", {31'b0, busy}, 32'd0);
                check("rst_addr", {27'b0, rd_addr}, 32'd0);
                check("rst_data", {24'b0, bus.out_data}, 32'd0);
                check("rst_last", {31'b0, bus.out_last}, 32'd0);
                @(negedge clk);
                check("rst_nodone", {31'b0, done}, 32'd0);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("rst_idle", {30'b0, busy, bus.out_valid}, 32'd0);
                check("rst_nodone2", {31'b0, done}, 32'd0);
                q.delete();
                return;
            end
        end
        check("done_seen", {31'b0, got_done}, 32'd1);
        if (!rnd && (mode == 0 || mode == 1))
            check("done_cycle", c, 162);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        repeat (4) step(rnd);
        check("frame_len", n_hs, FRAME_BYTES);
        check("done_pulses", n_done, 1);
        check("idle_after", {30'b0, busy, bus.out_valid}, 32'd0);
        check("queue_empty", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_last", {31'b0, bus.out_last}, 32'd0);
        check("reset_data", {24'b0, bus.out_data}, 32'd0);
        check("reset_addr", {27'b0, rd_addr}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_valid", {31'b0, bus.out_valid}, 32'd0);

        run_frame(1'b0, 0);
        check("csum_zero", {24'b0, last_csum}, 32'h00);

        rf[5] = 32'hDEADBEEF;
        run_frame(1'b0, 0);
        check("csum_dead", {24'b0, last_csum}, 32'h22);

        run_frame(1'b1, 0);
        check("csum_rand", {24'b0, last_csum}, 32'h22);

        rf[3] = 32'hCAFE0003;
        run_frame(1'b0, 1);
        check("late_write", rf[3], 32'hFFFFFFFF);

        run_frame(1'b0, 2);

        rf[12] = 32'h0C0C0C0C;
        run_frame(1'b0, 3);
        run_frame(1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out engine for the CPU register file. On a start pulse it walks all 32 architectural registers through a read port. It serializes each register into a byte stream with a valid/ready handshake, for the UART/debug link. It consumes the register file's read side, while the datapath drives the write side.

## Interface
- NREGS, 32: number of registers dumped, indices 0..NREGS-1
- ADDR_W, 5: register address width
- DATA_W, 32: register width; must be 32, sent as 4 bytes
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a dump; sampled only in IDLE
- rd_addr  out  ADDR_W  register read address to the register file
- rd_data  in  DATA_W  combinational read data for rd_addr; reg 0 reads 0
- out_valid  out  1  out_data holds a byte
- out_ready  in  1  sink accepts the byte when valid && ready
- out_data  out  8  stream byte
- out_last  out  1  marks the final byte (checksum); only meaningful with out_valid
- busy  out  1  high from the cycle after start until the last handshake
- done  out  1  one-cycle pulse the cycle after the last handshake

## Operation
- Frame, 162 bytes in order:
  - header 0xA5
  - for idx 0..31: address byte {3'b000, idx}, then rd_data[31:24], [23:16], [15:8], [7:0]
  - checksum byte: 8-bit XOR of every byte after the header and before the checksum
- FSM states:
  - IDLE -> HDR on start.
  - HDR -> ADDR on handshake.
  - ADDR -> DATA on handshake.
  - DATA -> ADDR on the handshake of byte 3 when idx < NREGS-1.
  - DATA -> CSUM on the handshake of byte 3 when idx = NREGS-1.
  - CSUM -> IDLE on handshake, with done pulsed.
- Counters: idx (ADDR_W bits) and byte counter bcnt (2 bits).
  - bcnt increments on each DATA handshake and wraps 3->0.
  - idx increments on the wrap.
- Capture: rd_addr = idx at all times. rd_data is latched into a 32-bit shift register on the ADDR-byte handshake.
  - Each register is therefore snapshotted individually at that instant.
  - Writes to not-yet-captured registers during a dump appear in the stream; writes to already-captured ones do not.
- Checksum register:
  - cleared entering HDR
  - XORed with out_data on every handshake in ADDR and DATA
- Handshake rules:
  - Once asserted, out_valid stays high and out_data/out_last stay stable until out_ready.
  - No combinational path from out_ready to out_valid.
- start while busy is ignored. start coincident with the final CSUM handshake is also ignored; a new start is accepted the cycle after done.
- Reset values:
  - state IDLE
  - out_valid, out_last, busy and done 0
  - out_data 0x00, rd_addr 0
  - idx, bcnt and checksum 0
- Reset mid-dump: the frame is aborted immediately, with all outputs at reset values; no done pulse, no partial checksum.

## Timing
- start high at edge T: out_valid = 1 with 0xA5 and busy = 1 from T+1.
- Each handshake advances the state at that edge. The next byte is valid in the following cycle, giving 1 byte per cycle at full throughput.
- With out_ready held high, there are exactly 162 consecutive valid cycles. The last handshake is at T+162, done = 1 during cycle T+163, and busy = 0 from T+163.
- Back-pressure stretches any byte indefinitely without changing frame content, except for snapshot timing.

## Structure
- Shared package reg_dump_pkg holds:
  - HDR_BYTE = 8'hA5
  - the state enum {IDLE, HDR, ADDR, DATA, CSUM}
  - FRAME_BYTES = 2 + 5*NREGS
- One natural sub-module, reg_dump_ser: a 32-bit load, 8-bit MSB-first shift stage with bcnt, driven by load/shift strobes from the FSM.
- The rest is a single FSM module of about 200 lines.

## Test plan
- Reset register file, start, ready always high:
  - stream is A5, 00 00000000, 01 00000000 … 1F 00000000, checksum
  - checksum = XOR of 0x00..0x1F = 0x00
  - done at T+163
- Preload reg5 = 0xDEADBEEF, others 0, ready high: bytes 26..30 are 05 DE AD BE EF, checksum = 0x00 ^ 0x1F-XOR ^ 0x05-already-included ^ DE^AD^BE^EF = 0x22.
- Random ready with 30% duty and the same preload:
  - byte sequence identical to the previous test
  - out_data never changes while valid && !ready
- Write reg31 = 0x12345678 while idx = 10, then write reg3 = 0xFFFFFFFF:
  - stream shows reg31 = 12345678 and reg3 = its old value
- Assert start during the dump at idx = 7: ignored, frame stays 162 bytes, and only one done pulse.
- Assert rst at idx = 12, bcnt = 2:
  - next cycle out_valid = 0, busy = 0, rd_addr = 0, no done
  - a fresh start yields a full correct frame
